nibble_serial_add_seq: RTL and testbench
========================================

Name: nibble_serial_add_seq

Overview:
- Upstream sequencer and downstream collector for the team's 4-bit registered full-adder stage.
- Accepts one WIDTH-bit operand pair plus carry-in via a valid/ready handshake.
- Issues the operands to the 4-bit adder one nibble at a time, LSB first, and chains the carry from add_sum[4] into the next nibble.
- Assembles the sum nibbles into a (WIDTH+1)-bit result and presents it through a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4. NIBBLES = WIDTH/4.
- ADDER_LAT, 1, clock edges from add_a/add_b/add_cin sampled to add_sum valid (1..7).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in
- add_a  output  4  nibble of A to the adder
- add_b  output  4  nibble of B to the adder
- add_cin  output  1  carry to the adder
- add_sum  input  5  adder result: [3:0] sum, [4] carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH+1  result; [WIDTH] is the final carry

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE; nibble index, wait counter and carry <= 0; out_sum <= 0; out_valid <= 0; add_a/add_b/add_cin <= 0.
  - in_ready is 0 while rst=1.
- Reset mid-operation: the in-flight operation is discarded with no output. Any add_sum arriving after reset is ignored.
- State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b; carry <= in_cin; idx <= 0; go to ISSUE.
- ISSUE (1 cycle):
  - add_a = A[4*idx+3:4*idx], add_b = B[4*idx+3:4*idx], add_cin = carry.
  - wcnt <= ADDER_LAT-1; go to WAIT.
- WAIT:
  - add_a/add_b/add_cin hold the ISSUE values.
  - If wcnt != 0: wcnt <= wcnt-1.
  - Otherwise capture: result[4*idx+3:4*idx] <= add_sum[3:0]; carry <= add_sum[4].
  - After capture: if idx == NIBBLES-1, out_sum[WIDTH] <= add_sum[4] and go to DONE; else idx <= idx+1 and go to ISSUE.
- DONE:
  - out_valid=1; out_sum stable; in_ready=0; add_* = 0.
  - On out_ready=1: go to IDLE, out_valid <= 0.
  - out_valid must not drop without a handshake.
- Latency:
  - Each nibble costs 1+ADDER_LAT cycles.
  - out_valid rises in cycle NIBBLES*(1+ADDER_LAT)+1 after the accepting edge (cycle 9 for the defaults).
  - Throughput: one operation per NIBBLES*(1+ADDER_LAT)+2 cycles when out_ready is held high.
- Single-operation policy: no new operand is accepted until the result handshakes. in_* is ignored outside IDLE.
- Arithmetic: out_sum = in_a + in_b + in_cin, exact, with no truncation at WIDTH+1 bits.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is accepted in the following IDLE cycle.
- add_sum is sampled only on the WAIT capture cycle. Its value at all other times is don't-care.

Test Plan:
- Adder model: registered A+B+Cin with ADDER_LAT=1.
  - Stimulus: in_a=16'h1234, in_b=16'h4321, in_cin=0.
  - Required: out_sum=17'h05555; out_valid rises exactly 9 cycles after the accepting edge.
- Full carry ripple.
  - Stimulus: 16'hFFFF + 16'h0001, cin=0.
  - Required: out_sum=17'h10000; add_cin=1 observed on nibbles 1, 2 and 3.
- Maximum operands.
  - Stimulus: 16'hFFFF + 16'hFFFF, cin=1.
  - Required: out_sum=17'h1FFFF.
- Output backpressure.
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 carrying a second pair.
  - Required: out_sum stable; in_ready=0 throughout; second pair accepted only after the output handshake, then computed correctly.
- Reset mid-operation.
  - Stimulus: assert rst during nibble 2 WAIT.
  - Required: next cycle out_valid=0, add_*=0, state IDLE; a subsequent 16'h0001+16'h0001 yields 17'h00002.
- Longer adder latency.
  - Stimulus: ADDER_LAT=3, WIDTH=8, 8'hA5 + 8'h5B, cin=1.
  - Required: out_sum=9'h101; out_valid rises 9 cycles after acceptance.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// Nibble-serial sequencer/collector around an external 4-bit registered adder.
// Ports: in_* operand handshake, add_* adder link, out_* result handshake.
module nibble_serial_add_seq #(
  parameter int WIDTH     = 16,
  parameter int ADDER_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [4:0]       add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  localparam logic [2:0]    WLD  = 3'(ADDER_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nx;
  logic [2:0]        wcnt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  res_nx;

  assign idx_nx   = idx + 1'b1;
  assign in_ready = (state == IDLE) && !rst;

  // Result with the nibble being captured this cycle merged in,
  // so the final nibble lands in out_sum on the same edge.
  always_comb begin
    res_nx = res;
    res_nx[4*idx +: 4] = add_sum[3:0];
  end

  // add_cin doubles as the running carry register: it holds the
  // carry into the nibble currently at the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      wcnt      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            idx     <= '0;
            res     <= '0;
            add_a   <= in_a[3:0];
            add_b   <= in_b[3:0];
            add_cin <= in_cin;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt  <= WLD;
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else begin
            res <= res_nx;
            if (idx == LAST) begin
              out_sum   <= {add_sum[4], res_nx};
              out_valid <= 1'b1;
              add_a     <= '0;
              add_b     <= '0;
              add_cin   <= 1'b0;
              state     <= DONE;
            end else begin
              idx     <= idx_nx;
              add_a   <= a_q[4*idx_nx +: 4];
              add_b   <= b_q[4*idx_nx +: 4];
              add_cin <= add_sum[4];
              state   <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq (16b/lat1 and 8b/lat3).
// Behavioural adder models feed add_sum; results checked against a+b+cin.
module tb_nibble_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_cin;
  logic [15:0] in_a, in_b;
  logic [3:0]  add_a, add_b;
  logic        add_cin;
  logic [4:0]  add_sum;
  logic        out_valid, out_ready;
  logic [16:0] out_sum;

  nibble_serial_add_seq #(.WIDTH(16), .ADDER_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum)
  );

  always @(posedge clk)
    add_sum <= 5'(add_a) + 5'(add_b) + 5'(add_cin);

  logic       w_in_valid, w_in_ready, w_in_cin;
  logic [7:0] w_in_a, w_in_b;
  logic [3:0] w_add_a, w_add_b;
  logic       w_add_cin;
  logic [4:0] w_add_sum;
  logic       w_out_valid, w_out_ready;
  logic [8:0] w_out_sum;
  logic [4:0] pipe [3];

  nibble_serial_add_seq #(.WIDTH(8), .ADDER_LAT(3)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin),
    .add_a(w_add_a), .add_b(w_add_b), .add_cin(w_add_cin),
    .add_sum(w_add_sum),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum)
  );

  always @(posedge clk) begin
    pipe[0] <= 5'(w_add_a) + 5'(w_add_b) + 5'(w_add_cin);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign w_add_sum = pipe[2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [16:0] ref16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  // Runs one operation on the 16-bit instance; entered between edges.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input int hold,
                       output logic [16:0] got, output int lat,
                       output logic [3:0] cins);
    int n;
    logic [16:0] s;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    cins = '0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (lat % 2 == 1 && lat < 9) cins[(lat-1)/2] = add_cin;
      @(posedge clk); #1; lat++;
    end
    got = out_sum;
    s = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sum", 32'(out_sum), 32'(s));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec8_t;

  initial begin
    vec_t        tbl [7];
    vec8_t       t8 [2];
    logic [16:0] got;
    logic [3:0]  cins;
    int          lat;
    logic [15:0] ra, rb;
    logic        rc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    tbl[6] = '{16'hABCD, 16'h1111, 1'b1, 17'h0BCDF};
    t8[0]  = '{8'hA5, 8'h5B, 1'b1, 9'h101};
    t8[1]  = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_cin = 0;
    w_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_add", 32'({add_a, add_b, add_cin}), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, i % 3, got, lat, cins);
      chk($sformatf("vec%0d_sum", i), 32'(got), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 9);
      if (i == 1) begin
        chk("ripple_cin0", 32'(cins[0]), 0);
        chk("ripple_cin1", 32'(cins[1]), 1);
        chk("ripple_cin2", 32'(cins[2]), 1);
        chk("ripple_cin3", 32'(cins[3]), 1);
      end
    end

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), got, lat, cins);
      chk("rand_sum", 32'(got), 32'(ref16(ra, rb, rc)));
      chk("rand_lat", 32'(lat), 9);
    end

    // Backpressure with a second pair waiting.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_lat", 32'(lat), 9);
    chk("bp_sum", 32'(out_sum), 32'h03333);
    in_a = 16'h8001; in_b = 16'h7FFF; in_cin = 0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_stable", 32'(out_sum), 32'h03333);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_drop", 32'(out_valid), 0);
    chk("bp_idle", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp2_lat", 32'(lat), 9);
    chk("bp2_sum", 32'(out_sum), 32'(ref16(16'h8001, 16'h7FFF, 1'b0)));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during nibble 2 WAIT.
    in_a = 16'h5A3C; in_b = 16'h1234; in_cin = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_add_a", 32'(add_a), 32'hA);
    chk("mid_add_b", 32'(add_b), 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_add", 32'({add_a, add_b, add_cin}), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("mrst_idle", 32'(in_ready), 1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("mrst_no_out", 32'(lat), 0);
    do_op(16'h0001, 16'h0001, 1'b0, 0, got, lat, cins);
    chk("mrst_next_sum", 32'(got), 32'h00002);

    // 8-bit instance, ADDER_LAT = 3.
    for (int i = 0; i < 2; i++) begin
      w_in_a = t8[i].a; w_in_b = t8[i].b; w_in_cin = t8[i].cin;
      w_in_valid = 1'b1;
      lat = 0;
      while (!w_in_ready && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      chk("w8_ready", 32'(w_in_ready), 1);
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 100) begin
        @(posedge clk); #1; lat++;
      end
      chk($sformatf("w8_%0d_lat", i), 32'(lat), 9);
      chk($sformatf("w8_%0d_sum", i), 32'(w_out_sum), 32'(t8[i].exp));
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      w_out_ready = 1'b0;
      chk("w8_drop", 32'(w_out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
